// File: rtl/mouse_sequence_decoder_pkg.sv
// Shared constants and types for the mouse report sequence decoder.
// Report format: header 8'h1E, X byte, Y byte, modifier byte.
// No ports (package only).
package mouse_sequence_decoder_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned X_W    = 7;
    localparam int unsigned Y_W    = 6;
    localparam int unsigned MOD_W  = 7;

    localparam logic [BYTE_W-1:0] MOUSE_SEQ_HEADER = 8'h1E;

    // Modifier byte bit positions
    localparam int unsigned MOD_LEFT   = 0;
    localparam int unsigned MOD_RIGHT  = 1;
    localparam int unsigned MOD_MIDDLE = 2;
    localparam int unsigned MOD_SHIFT  = 3;
    localparam int unsigned MOD_CTRL   = 4;
    localparam int unsigned MOD_ALT    = 5;
    localparam int unsigned MOD_META   = 6;

    // Marker bits: every payload byte has bit7 set; Y bytes also have bit6 clear
    localparam int unsigned SEQ_MARK_BIT = 7;
    localparam int unsigned Y_ZERO_BIT   = 6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_X   = 2'd1,
        ST_WAIT_Y   = 2'd2,
        ST_WAIT_MOD = 2'd3
    } seq_state_e;

    // Decoded event payload, held between valid events
    typedef struct packed {
        logic [MOD_W-1:0] mods;
        logic [Y_W-1:0]   y;
        logic [X_W-1:0]   x;
    } mouse_event_t;

endpackage : mouse_sequence_decoder_pkg

// File: rtl/mouse_sequence_timeout.sv
// Inter-byte idle timeout for a partial mouse sequence.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   active_i    - decoder is inside a sequence (not IDLE)
//   clear_i     - a byte was accepted this cycle
//   timeout_c   - combinational: idle count has reached TIMEOUT_CYCLES
// Only instantiated when MOUSE_SEQUENCE_DECODER_TIMEOUT_EN is defined.
module mouse_sequence_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic active_i,
    input  logic clear_i,
    output logic timeout_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_c = active_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // Count idle cycles inside a sequence; restart on any byte or on expiry
    always_comb begin
        cnt_d = cnt_q;
        if (!active_i || clear_i || timeout_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : mouse_sequence_timeout

// File: rtl/mouse_sequence_decoder.sv
// Mouse report sequence decoder: recovers text coordinates, buttons and
// keyboard modifiers from 1E/X/Y/MOD sequences and passes every other byte
// through unchanged.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   byte_in, byte_in_valid        - received byte stream (no backpressure)
//   byte_out, byte_out_valid      - passthrough byte, 1-cycle pulse
//   event_valid                   - 1-cycle pulse, decoded event updated
//   x_text, y_text                - decoded column / row (held)
//   button_*, keyboard_*          - decoded modifier bits (held)
//   seq_error                     - 1-cycle pulse, partial sequence aborted
// Optional: MOUSE_SEQUENCE_DECODER_TIMEOUT_EN adds an inter-byte timeout.
module mouse_sequence_decoder
    import mouse_sequence_decoder_pkg::*;
#(
    parameter int unsigned TEXT_COLS      = 80,
    parameter int unsigned TEXT_ROWS      = 51,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_in_valid,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_out_valid,
    output logic              event_valid,
    output logic [X_W-1:0]    x_text,
    output logic [Y_W-1:0]    y_text,
    output logic              button_left,
    output logic              button_right,
    output logic              button_middle,
    output logic              keyboard_shift,
    output logic              keyboard_ctrl,
    output logic              keyboard_alt,
    output logic              keyboard_meta,
    output logic              seq_error
);

    seq_state_e        state_q, state_d, cur_state;
    logic [X_W-1:0]    x_cap_q, x_cap_d;
    logic [Y_W-1:0]    y_cap_q, y_cap_d;
    mouse_event_t      evt_q, evt_d;
    logic [BYTE_W-1:0] byte_out_q, byte_out_d;
    logic              bov_q, bov_d;
    logic              ev_q, ev_d;
    logic              err_q, err_d;
    logic              as_idle;
    logic              timeout_hit;
    logic              x_ok, y_ok, mod_ok;

`ifdef MOUSE_SEQUENCE_DECODER_TIMEOUT_EN
    mouse_sequence_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .active_i  (state_q != ST_IDLE),
        .clear_i   (byte_in_valid),
        .timeout_c (timeout_hit)
    );
`else
    // Timeout compiled out; the parameter is still consumed so both builds
    // present the same parameter interface.
    assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    // Per-byte field checks
    assign x_ok   = byte_in[SEQ_MARK_BIT] && (32'(byte_in[X_W-1:0]) < TEXT_COLS);
    assign y_ok   = byte_in[SEQ_MARK_BIT] && !byte_in[Y_ZERO_BIT]
                    && (32'(byte_in[Y_W-1:0]) < TEXT_ROWS);
    assign mod_ok = byte_in[SEQ_MARK_BIT];

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        x_cap_d    = x_cap_q;
        y_cap_d    = y_cap_q;
        evt_d      = evt_q;
        byte_out_d = byte_out_q;
        bov_d      = 1'b0;
        ev_d       = 1'b0;
        err_d      = 1'b0;
        as_idle    = 1'b0;
        cur_state  = state_q;

        // An expired sequence behaves as IDLE for a byte arriving this cycle
        if (timeout_hit) begin
            err_d     = 1'b1;
            state_d   = ST_IDLE;
            cur_state = ST_IDLE;
        end

        if (byte_in_valid) begin
            unique case (cur_state)
                ST_IDLE: begin
                    as_idle = 1'b1;
                end
                ST_WAIT_X: begin
                    if (x_ok) begin
                        x_cap_d = byte_in[X_W-1:0];
                        state_d = ST_WAIT_Y;
                    end else begin
                        err_d   = 1'b1;
                        as_idle = 1'b1;
                    end
                end
                ST_WAIT_Y: begin
                    if (y_ok) begin
                        y_cap_d = byte_in[Y_W-1:0];
                        state_d = ST_WAIT_MOD;
                    end else begin
                        err_d   = 1'b1;
                        as_idle = 1'b1;
                    end
                end
                ST_WAIT_MOD: begin
                    if (mod_ok) begin
                        evt_d.mods = byte_in[MOD_W-1:0];
                        evt_d.x    = x_cap_q;
                        evt_d.y    = y_cap_q;
                        ev_d       = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        as_idle = 1'b1;
                    end
                end
                default: begin
                    as_idle = 1'b1;
                end
            endcase

            // Malformed bytes are re-handled as fresh IDLE input
            if (as_idle) begin
                if (byte_in == MOUSE_SEQ_HEADER) begin
                    state_d = ST_WAIT_X;
                end else begin
                    state_d    = ST_IDLE;
                    byte_out_d = byte_in;
                    bov_d      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            x_cap_q    <= '0;
            y_cap_q    <= '0;
            evt_q      <= '0;
            byte_out_q <= '0;
            bov_q      <= 1'b0;
            ev_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_cap_q    <= x_cap_d;
            y_cap_q    <= y_cap_d;
            evt_q      <= evt_d;
            byte_out_q <= byte_out_d;
            bov_q      <= bov_d;
            ev_q       <= ev_d;
            err_q      <= err_d;
        end
    end

    assign byte_out       = byte_out_q;
    assign byte_out_valid = bov_q;
    assign event_valid    = ev_q;
    assign seq_error      = err_q;
    assign x_text         = evt_q.x;
    assign y_text         = evt_q.y;
    assign button_left    = evt_q.mods[MOD_LEFT];
    assign button_right   = evt_q.mods[MOD_RIGHT];
    assign button_middle  = evt_q.mods[MOD_MIDDLE];
    assign keyboard_shift = evt_q.mods[MOD_SHIFT];
    assign keyboard_ctrl  = evt_q.mods[MOD_CTRL];
    assign keyboard_alt   = evt_q.mods[MOD_ALT];
    assign keyboard_meta  = evt_q.mods[MOD_META];

endmodule : mouse_sequence_decoder

// File: tb/tb_mouse_sequence_decoder.sv
// Scoreboard bench for mouse_sequence_decoder: directed byte vectors push
// expected output records; a monitor pops and compares on every output pulse.
module tb_mouse_sequence_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] byte_in;
    logic       byte_in_valid;
    logic [7:0] byte_out;
    logic       byte_out_valid;
    logic       event_valid;
    logic [6:0] x_text;
    logic [5:0] y_text;
    logic       button_left, button_right, button_middle;
    logic       keyboard_shift, keyboard_ctrl, keyboard_alt, keyboard_meta;
    logic       seq_error;
    logic [6:0] dut_m;

    typedef struct {
        logic       bov;
        logic [7:0] bo;
        logic       err;
        logic       ev;
        logic [6:0] x;
        logic [5:0] y;
        logic [6:0] m;
    } rec_t;

    rec_t       sb_q[$];
    logic [6:0] held_x;
    logic [5:0] held_y;
    logic [6:0] held_m;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    mouse_sequence_decoder dut (
        .clk            (clk),
        .reset          (reset),
        .byte_in        (byte_in),
        .byte_in_valid  (byte_in_valid),
        .byte_out       (byte_out),
        .byte_out_valid (byte_out_valid),
        .event_valid    (event_valid),
        .x_text         (x_text),
        .y_text         (y_text),
        .button_left    (button_left),
        .button_right   (button_right),
        .button_middle  (button_middle),
        .keyboard_shift (keyboard_shift),
        .keyboard_ctrl  (keyboard_ctrl),
        .keyboard_alt   (keyboard_alt),
        .keyboard_meta  (keyboard_meta),
        .seq_error      (seq_error)
    );

    assign dut_m = {keyboard_meta, keyboard_alt, keyboard_ctrl, keyboard_shift,
                    button_middle, button_right, button_left};

    task automatic push(input logic bov, input logic [7:0] bo,
                        input logic err, input logic ev);
        rec_t r;
        r.bov = bov; r.bo = bo; r.err = err; r.ev = ev;
        r.x = held_x; r.y = held_y; r.m = held_m;
        sb_q.push_back(r);
    endtask

    task automatic exp_pass(input logic [7:0] b);
        push(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic exp_err();
        push(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic exp_err_pass(input logic [7:0] b);
        push(1'b1, b, 1'b1, 1'b0);
    endtask

    task automatic exp_event(input logic [6:0] x, input logic [5:0] y, input logic [6:0] m);
        held_x = x; held_y = y; held_m = m;
        push(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic send(input logic [7:0] b);
        byte_in       = b;
        byte_in_valid = 1'b1;
        @(posedge clk); #1;
        byte_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: every output pulse must match the oldest expected record
    task automatic monitor();
        rec_t r;
        forever begin
            @(negedge clk);
            if (byte_out_valid || seq_error || event_valid) begin
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: bov=%0b bo=%02h err=%0b ev=%0b, expected no output",
                             byte_out_valid, byte_out, seq_error, event_valid);
                end else begin
                    r = sb_q.pop_front();
                    if (r.bov !== byte_out_valid || r.err !== seq_error || r.ev !== event_valid ||
                        (r.bov && r.bo !== byte_out) || r.x !== x_text || r.y !== y_text ||
                        r.m !== dut_m) begin
                        fails++;
                        $display("FAIL output_record @%0t: got bov=%0b bo=%02h err=%0b ev=%0b x=%0d y=%0d m=%02h, expected bov=%0b bo=%02h err=%0b ev=%0b x=%0d y=%0d m=%02h",
                                 $time, byte_out_valid, byte_out, seq_error, event_valid,
                                 x_text, y_text, dut_m, r.bov, r.bo, r.err, r.ev, r.x, r.y, r.m);
                    end
                end
            end
        end
    endtask

    task automatic check_zero(input string name);
        @(negedge clk);
        tests++;
        if (byte_out !== 8'h00 || byte_out_valid !== 1'b0 || event_valid !== 1'b0 ||
            seq_error !== 1'b0 || x_text !== 7'd0 || y_text !== 6'd0 || dut_m !== 7'd0) begin
            fails++;
            $display("FAIL %s: got bo=%02h bov=%0b ev=%0b err=%0b x=%0d y=%0d m=%02h, expected all zero",
                     name, byte_out, byte_out_valid, event_valid, seq_error, x_text, y_text, dut_m);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; byte_in = 8'h00; byte_in_valid = 1'b0;
        held_x = '0; held_y = '0; held_m = '0;
        fork
            monitor();
        join_none
        idle(2);
        check_zero("reset_state");
        reset = 1'b0;
        idle(1);

        // Basic event
        send(8'h1E); send(8'h8A); send(8'h85);
        exp_event(7'd10, 6'd5, 7'h09); send(8'h89);
        // Passthrough around an event
        exp_pass(8'h41); send(8'h41);
        send(8'h1E); send(8'h81); send(8'h82);
        exp_event(7'd1, 6'd2, 7'h40); send(8'hC0);
        exp_pass(8'h42); send(8'h42);
        // Y with bit6 set: abort and pass through, held outputs unchanged
        send(8'h1E); send(8'h8A);
        exp_err_pass(8'hC5); send(8'hC5);
        // X out of range
        send(8'h1E);
        exp_err_pass(8'hD0); send(8'hD0);
        send(8'h1E); send(8'h80); send(8'h80);
        exp_event(7'd0, 6'd0, 7'h00); send(8'h80);
        // Range boundaries: X=79, Y=50 accepted; Y=51 rejected
        send(8'h1E); send(8'hCF); send(8'hB2);
        exp_event(7'd79, 6'd50, 7'h00); send(8'h80);
        send(8'h1E); send(8'hCF);
        exp_err_pass(8'hB3); send(8'hB3);
        // Header inside WAIT_X, WAIT_Y, WAIT_MOD restarts the sequence
        send(8'h1E);
        exp_err(); send(8'h1E);
        send(8'h8A); send(8'h85);
        exp_event(7'd10, 6'd5, 7'h09); send(8'h89);
        send(8'h1E); send(8'h85);
        exp_err(); send(8'h1E);
        send(8'h8A); send(8'h85);
        exp_err(); send(8'h1E);
        send(8'h81); send(8'h82);
        exp_event(7'd1, 6'd2, 7'h7F); send(8'hFF);
        // Modifier byte without marker bit
        send(8'h1E); send(8'h80); send(8'h80);
        exp_err_pass(8'h00); send(8'h00);
        // Idle gap mid-sequence: sequence resumes (no timeout in default build)
        send(8'h1E); send(8'h83);
        idle(20);
        send(8'h84);
        exp_event(7'd3, 6'd4, 7'h02); send(8'h82);
        // Reset mid-sequence, with a simultaneous byte that must be discarded
        send(8'h1E); send(8'h8A);
        reset = 1'b1; byte_in = 8'h41; byte_in_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; byte_in_valid = 1'b0;
        held_x = '0; held_y = '0; held_m = '0;
        check_zero("reset_mid_sequence");
        exp_pass(8'h85); send(8'h85);

        // Drain, bounded
        idle(3);
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) idle(1);
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d records outstanding, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_mouse_sequence_decoder
